// File: rtl/muldiv_if.sv
// Handshake and operand/result bundle between the EX stage and the RV32M
// multiply/divide sequencer.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, op_a_i, op_b_i, flush_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, op_a_i, op_b_i, flush_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, XLEN iterations, sign fix-up on the last one.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [2:0]      op_reg;
    logic [XLEN-1:0] opnd_reg;
    logic [XLEN-1:0] result_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic            neg_reg;
    logic            rem_neg_reg;

    // Accept-cycle decode of signedness, magnitudes and the divide special cases
    logic            is_div, a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        is_div   = bus.funct3_i[2];
        a_signed = is_div ? !bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
        b_signed = is_div ? !bus.funct3_i[0] : !bus.funct3_i[1];
        a_neg    = a_signed & bus.op_a_i[XLEN-1];
        b_neg    = b_signed & bus.op_b_i[XLEN-1];
        a_mag    = a_neg ? -bus.op_a_i : bus.op_a_i;
        b_mag    = b_neg ? -bus.op_b_i : bus.op_b_i;
        div_zero = is_div && (bus.op_b_i == '0);
        div_ovf  = is_div && !bus.funct3_i[0] && (bus.op_a_i == MOST_NEG) && (bus.op_b_i == '1);
        if (div_zero)
            special_res = bus.funct3_i[1] ? bus.op_a_i : '1;
        else
            special_res = bus.funct3_i[1] ? '0 : MOST_NEG;
    end

    // acc_reg holds {high, low}: {product high, multiplier} or {remainder, quotient}
    logic [XLEN:0]     add_sum, trial;
    logic [2*XLEN-1:0] acc_next, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    always_comb begin
        add_sum = {1'b0, acc_reg[2*XLEN-1:XLEN]}
                + (acc_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});
        trial   = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]} - {1'b0, opnd_reg};
        if (op_reg[2])
            acc_next = trial[XLEN] ? {acc_reg[2*XLEN-2:0], 1'b0}
                                   : {trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        else
            acc_next = {add_sum, acc_reg[XLEN-1:1]};

        prod = neg_reg ? -acc_next : acc_next;
        quo  = neg_reg ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem  = rem_neg_reg ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        if (op_reg[2])
            final_res = op_reg[1] ? rem : quo;
        else if (op_reg[1:0] == 2'b00)
            final_res = prod[XLEN-1:0];
        else
            final_res = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            op_reg      <= '0;
            opnd_reg    <= '0;
            result_reg  <= '0;
            acc_reg     <= '0;
            neg_reg     <= 1'b0;
            rem_neg_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        op_reg      <= bus.funct3_i;
                        cnt_reg     <= '0;
                        neg_reg     <= a_neg ^ b_neg;
                        rem_neg_reg <= a_neg;
                        opnd_reg    <= is_div ? b_mag : a_mag;
                        acc_reg     <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        if (div_zero || div_ovf) begin
                            result_reg <= special_res;
                            state_reg  <= DONE;
                        end else begin
                            state_reg  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush_i) begin
                        state_reg <= IDLE;
                    end else begin
                        acc_reg <= acc_next;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == CW'(XLEN-1)) begin
                            result_reg <= final_res;
                            state_reg  <= DONE;
                        end
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // DONE never stalls, so the pipeline advances on the edge that consumes the result
    assign bus.stall_o  = !reset && !bus.flush_i
                        && (((state_reg == IDLE) && bus.start_i) || (state_reg == CALC));
    assign bus.busy_o   = !reset && (state_reg != IDLE);
    assign bus.done_o   = !reset && (state_reg == DONE);
    assign bus.result_o = bus.done_o ? result_reg : '0;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: results, latency, stall shape,
// flush/reset abort and back-to-back issue.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(32)) bus();
    muldiv_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 of an idle cycle; that cycle is cycle 0 (accept).
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int done_cyc = -1;
        int pulses = 0;
        int stall_bad = 0;
        int zero_bad = 0;
        logic [31:0] res = '0;
        bus.start_i  = 1'b1;
        bus.funct3_i = f3;
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        @(negedge clk);
        if (!bus.stall_o) stall_bad++;
        next_cycle();
        bus.start_i  = 1'b0;
        bus.funct3_i = 3'($urandom_range(0, 7));
        bus.op_a_i   = $urandom;
        bus.op_b_i   = $urandom;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            if (bus.done_o) begin
                pulses++;
                done_cyc = c;
                res = bus.result_o;
            end else if (bus.result_o != '0) begin
                zero_bad++;
            end
            if (bus.stall_o != (c < lat)) stall_bad++;
            if (c == lat + 1) check({tag, " busy_after"}, 32'(bus.busy_o), 32'd0);
            next_cycle();
        end
        check({tag, " result"}, res, exp);
        check({tag, " done_cycle"}, done_cyc, lat);
        check({tag, " done_pulses"}, pulses, 1);
        check({tag, " stall_bad_cycles"}, stall_bad, 0);
        check({tag, " result_not_zero"}, zero_bad, 0);
        $display("op %s f3=%0d a=%08h b=%08h -> %08h at cycle %0d", tag, f3, a, b, res, done_cyc);
    endtask

    // DIV aborted in cycle 10 by flush or reset, then MUL 3*4 accepted in cycle 11.
    task automatic abort_test(input bit use_reset);
        string tag = use_reset ? "abort_reset" : "abort_flush";
        int pulses = 0;
        int done_cyc = -1;
        logic [31:0] res = '0;
        bus.start_i  = 1'b1;
        bus.funct3_i = 3'b100;
        bus.op_a_i   = 32'hFFFF_FFF9;
        bus.op_b_i   = 32'd2;
        for (int c = 0; c <= 46; c++) begin
            if (c == 1) bus.start_i = 1'b0;
            if (c == 10) begin
                if (use_reset) reset = 1'b1;
                else bus.flush_i = 1'b1;
            end
            if (c == 11) begin
                reset        = 1'b0;
                bus.flush_i  = 1'b0;
                bus.start_i  = 1'b1;
                bus.funct3_i = 3'b000;
                bus.op_a_i   = 32'd3;
                bus.op_b_i   = 32'd4;
            end
            if (c == 12) bus.start_i = 1'b0;
            @(negedge clk);
            if (c == 10) check({tag, " stall_in_abort"}, 32'(bus.stall_o), 32'd0);
            if (c == 11) begin
                check({tag, " busy_after_abort"}, 32'(bus.busy_o), 32'd0);
                check({tag, " stall_new_accept"}, 32'(bus.stall_o), 32'd1);
            end
            if (bus.done_o) begin
                pulses++;
                done_cyc = c;
                res = bus.result_o;
            end
            next_cycle();
        end
        check({tag, " done_pulses"}, pulses, 1);
        check({tag, " done_cycle"}, done_cyc, 44);
        check({tag, " mul_result"}, res, 32'd12);
        $display("op %s: MUL 3*4 -> %08h at cycle %0d", tag, res, done_cyc);
    endtask

    // MUL 3*5 then DIVU 100/7 with start_i held high across the first DONE.
    task automatic back_to_back();
        int pulses = 0;
        int done1 = -1;
        int done2 = -1;
        logic [31:0] res1 = '0;
        logic [31:0] res2 = '0;
        bus.start_i  = 1'b1;
        bus.funct3_i = 3'b000;
        bus.op_a_i   = 32'd3;
        bus.op_b_i   = 32'd5;
        for (int c = 0; c <= 70; c++) begin
            if (c == 1) begin
                bus.funct3_i = 3'b101;
                bus.op_a_i   = 32'd100;
                bus.op_b_i   = 32'd7;
            end
            if (c == 35) bus.start_i = 1'b0;
            @(negedge clk);
            if (c == 33) check("b2b stall_in_done", 32'(bus.stall_o), 32'd0);
            if (c == 34) begin
                check("b2b busy_second_accept", 32'(bus.busy_o), 32'd0);
                check("b2b stall_second_accept", 32'(bus.stall_o), 32'd1);
            end
            if (bus.done_o) begin
                pulses++;
                if (done1 < 0) begin
                    done1 = c;
                    res1 = bus.result_o;
                end else begin
                    done2 = c;
                    res2 = bus.result_o;
                end
            end
            next_cycle();
        end
        check("b2b done_pulses", pulses, 2);
        check("b2b mul_cycle", done1, 33);
        check("b2b mul_result", res1, 32'd15);
        check("b2b divu_cycle", done2, 67);
        check("b2b divu_result", res2, 32'd14);
        $display("op b2b: MUL -> %08h at %0d, DIVU -> %08h at %0d", res1, done1, res2, done2);
    endtask

    initial begin
        bus.start_i  = 1'b1;
        bus.flush_i  = 1'b0;
        bus.funct3_i = 3'b000;
        bus.op_a_i   = 32'd7;
        bus.op_b_i   = 32'd3;
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        check("reset stall", 32'(bus.stall_o), 32'd0);
        check("reset busy", 32'(bus.busy_o), 32'd0);
        check("reset done", 32'(bus.done_o), 32'd0);
        check("reset result", bus.result_o, 32'd0);
        next_cycle();
        reset = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        check("post_reset busy", 32'(bus.busy_o), 32'd0);
        next_cycle();

        run_op("mul",      3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhu",    3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        run_op("div",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",     3'b101, 32'd100,       32'd7,         32'd14,        33);
        run_op("remu",     3'b111, 32'd100,       32'd7,         32'd2,         33);
        run_op("divu_by0", 3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_by0",  3'b110, 32'd5,         32'd0,         32'd5,         1);
        run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        abort_test(1'b0);
        abort_test(1'b1);
        back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
